// File: rtl/fifo_reg_buf_pkg.sv
// Shared helpers for the register-array FIFO.
// Width math used by fifo_reg_buf.
package fifo_reg_buf_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_reg_buf.sv
// Synchronous FIFO on a register array with registered read data,
// occupancy/threshold flags and sticky overflow/underflow errors.
module fifo_reg_buf
  import fifo_reg_buf_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 8,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2,
  localparam int CW    = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_wf,
  input  logic [DWIDTH-1:0] in_d,
  input  logic              i_rf,
  output logic [DWIDTH-1:0] ot_d,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_afull,
  output logic              o_aempty,
  output logic [CW-1:0]     o_cnt,
  output logic              o_ovf,
  output logic              o_udf
);

  localparam int PW = clog2(DEPTH);
  localparam logic [PW-1:0] PLAST = PW'(DEPTH - 1);

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  logic [CW-1:0]     r_cnt;
  logic [DWIDTH-1:0] r_d;
  logic              r_ovf;
  logic              r_udf;

  logic w_rd;
  logic w_wr;
  logic w_full;
  logic w_empty;

  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_rd    = i_rf && !w_empty;
  // A full FIFO still takes a write when a read frees a slot this edge.
  assign w_wr    = i_wf && (!w_full || w_rd);

  always_ff @(posedge clk) begin
    if (w_wr && !i_clr) r_mem[r_wp] <= in_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_d   <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (i_clr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_wr) r_wp <= (r_wp == PLAST) ? '0 : r_wp + 1'b1;
      if (w_rd) begin
        r_rp <= (r_rp == PLAST) ? '0 : r_rp + 1'b1;
        r_d  <= r_mem[r_rp];
      end
      if (w_wr && !w_rd) r_cnt <= r_cnt + 1'b1;
      else if (w_rd && !w_wr) r_cnt <= r_cnt - 1'b1;
      if (i_wf && !w_wr) r_ovf <= 1'b1;
      if (i_rf && w_empty) r_udf <= 1'b1;
    end
  end

  assign ot_d     = r_d;
  assign o_cnt    = r_cnt;
  assign o_full   = w_full;
  assign o_empty  = w_empty;
  assign o_afull  = (r_cnt >= CW'(AF_LVL));
  assign o_aempty = (r_cnt <= CW'(AE_LVL));
  assign o_ovf    = r_ovf;
  assign o_udf    = r_udf;

endmodule

// File: doc/fifo_reg_buf.md
FIFO_REG_BUF -- requirements
Module: fifo_reg_buf

Interface
REQ-001 SHALL have parameter DWIDTH, default 8: data width in bits, ≥1.
REQ-002 SHALL have parameter DEPTH, default 8: number of entries, ≥2, any integer (power of two not required).
REQ-003 SHALL have parameter AF_LVL, default DEPTH-2: almost-full threshold, 1..DEPTH-1.
REQ-004 SHALL have parameter AE_LVL, default 2: almost-empty threshold, 1..DEPTH-1.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port i_clr, input, 1 bit: synchronous flush.
REQ-008 SHALL have port i_wf, input, 1 bit: write request.
REQ-009 SHALL have port in_d, input, DWIDTH bits: write data.
REQ-010 SHALL have port i_rf, input, 1 bit: read request.
REQ-011 SHALL have port ot_d, output, DWIDTH bits: registered read data.
REQ-012 SHALL have ports o_full and o_empty, outputs, 1 bit each: occupancy flags.
REQ-013 SHALL have ports o_afull and o_aempty, outputs, 1 bit each: threshold flags.
REQ-014 SHALL have port o_cnt, output, CW = ceil(log2(DEPTH+1)) bits: current entry count.
REQ-015 SHALL have ports o_ovf and o_udf, outputs, 1 bit each: sticky error flags.

Function
REQ-016 SHALL accept a write when i_wf=1 and either count<DEPTH or an accepted read occurs in the same cycle; it stores in_d at wr_ptr and advances wr_ptr.
REQ-017 SHALL accept a read when i_rf=1 and count>0; on that edge it loads ot_d with mem[rd_ptr] and advances rd_ptr.
REQ-018 SHALL hold ot_d in every cycle with no accepted read.
REQ-019 SHALL wrap both pointers from DEPTH-1 to 0.
REQ-020 SHALL update count as +1 on a write only, -1 on a read only, and leave it unchanged on both or neither.
REQ-021 SHALL derive all flags from the registered count: o_full = count==DEPTH; o_empty = count==0; o_afull = count>=AF_LVL; o_aempty = count<=AE_LVL.
REQ-022 SHALL give write-to-read latency as follows: data written at edge N deasserts o_empty after edge N; a read presented at edge N+1 shows that data on ot_d after edge N+1.
REQ-023 SHALL treat a write while full with no accepted read as an overflow: data is dropped, state is unchanged, and o_ovf is set.
REQ-024 SHALL treat a read while empty as an underflow, even with a simultaneous write: the read is ignored, ot_d holds, the write is accepted, and o_udf is set.
REQ-025 SHALL keep o_ovf and o_udf set until reset or i_clr.
REQ-026 SHALL, on i_clr=1, zero the pointers, count, o_ovf and o_udf at that edge; i_clr overrides same-cycle reads and writes; ot_d and memory contents are untouched.
REQ-027 SHALL hold the state of unwritten memory entries unchanged; memory needs no reset.

Reset
REQ-028 SHALL, while rst_n=0, set immediately: ot_d=0, pointers=0, o_cnt=0, o_empty=1, o_full=0, o_aempty=1, o_afull=0, o_ovf=0, o_udf=0.
REQ-029 SHALL discard all buffered entries when reset asserts mid-operation; on the first edge after release, the block accepts writes normally.

Structure
REQ-030 SHALL take CW and the pointer width from a shared package function clog2; no typedefs are required.
REQ-031 SHALL be implemented as a single module with a register-array memory; it has no sub-modules.

Verification
REQ-032 SHALL cover fill and drain: with DEPTH=8, write 0x01..0x08; o_full=1 and o_cnt=8; read 8 times; ot_d sequence is 0x01..0x08, then o_empty=1.
REQ-033 SHALL cover overflow: while full, write 0xAA; o_ovf=1, o_cnt stays 8, and the drain returns no 0xAA.
REQ-034 SHALL cover simultaneous read and write: at count=8, read and write 0x55 together; o_cnt stays 8 and 0x55 is read last; at count=0, both together give o_udf=1, o_cnt=1, ot_d held.
REQ-035 SHALL cover wrap: run 20 alternating write/read pairs of 0x10..0x23; the outputs match in order and o_cnt never exceeds 1.
REQ-036 SHALL cover thresholds: with AF_LVL=6 and AE_LVL=2, o_afull rises on the 6th write and o_aempty falls on the 3rd write.
REQ-037 SHALL cover reset and clear: assert rst_n=0 mid-burst at count=5, so o_cnt=0 asynchronously; then fill 3 entries and pulse i_clr with i_wf=1, giving o_cnt=0 and o_empty=1.
